// File: rtl/ubaintr_pkg.sv
// Shared types and constants for the UBA interrupt-acknowledge arbiter.
// Vector-word bit positions use PDP-10 numbering (bit 0 is the MSB).
package ubaintr_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StArb,
        StGrant,
        StDone
    } state_e;

    // BR level index = BR number minus BrBase
    localparam int unsigned BrBase = 4;
    localparam int unsigned LvlBr7 = 3;
    localparam int unsigned LvlBr6 = 2;
    localparam int unsigned LvlBr5 = 1;
    localparam int unsigned LvlBr4 = 0;

    localparam int unsigned VectMsb = 20;
    localparam int unsigned VectLsb = 35;
    localparam int unsigned VectW   = VectLsb - VectMsb + 1;
    localparam int unsigned PadW    = VectMsb;

    localparam int unsigned CntW = 6;

    function automatic logic [3:0] br_onehot(input logic [1:0] lvl);
        return 4'b0001 << lvl;
    endfunction

endpackage

// File: rtl/uba_intr_prio.sv
// Combinational priority picker: highest BR level first, then lowest device number.
module uba_intr_prio
    import ubaintr_pkg::*;
(
    input  logic [7:4] req_i [1:5],
    output logic [2:0] dev_o,
    output logic [1:0] lvl_o,
    output logic       valid_o
);

    always_comb begin
        dev_o   = '0;
        lvl_o   = '0;
        valid_o = 1'b0;
        for (int lv = 3; lv >= 0; lv--) begin
            for (int d = 1; d <= 5; d++) begin
                if (!valid_o && req_i[d][BrBase + lv]) begin
                    valid_o = 1'b1;
                    dev_o   = 3'(d);
                    lvl_o   = 2'(lv);
                end
            end
        end
    end

endmodule

// File: rtl/uba_intr_ack.sv
// UBA interrupt-acknowledge arbiter: picks a requester, grants it, returns its vector.
// Define UBA_INTR_TIMEOUT_EN to compile in the grant-wait timeout (TIMEOUT cycles).
module uba_intr_ack
    import ubaintr_pkg::*;
#(
    parameter int unsigned TIMEOUT = 63
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        vectREAD,
    input  logic [2:0]  vectPI,
    input  logic [0:35] regUBASR,
    input  logic [7:4]  devINTR [1:5],
    input  logic [15:0] devVECT [1:5],
    input  logic        devVECTV [1:5],
    output logic [7:4]  devACKO [1:5],
    output logic [0:35] vectDATA,
    output logic        vectDONE,
    output logic        vectERR
);

    state_e      state_q, state_d;
    logic [2:0]  pi_q, pi_d;
    logic [2:0]  win_dev_q, win_dev_d;
    logic [1:0]  win_lvl_q, win_lvl_d;
    logic [0:35] data_q, data_d;
    logic        err_q, err_d;

    logic [2:0]  stat_pih, stat_pil;
    logic        hi_en, lo_en;
    logic [7:4]  masked [1:5];
    logic [2:0]  prio_dev;
    logic [1:0]  prio_lvl;
    logic        prio_valid;
    logic        sel_vv;
    logic [15:0] sel_vect;
    logic        timeout_hit;

    logic unused_sr;
    assign unused_sr = ^regUBASR[0:29];

    assign stat_pih = regUBASR[30:32];
    assign stat_pil = regUBASR[33:35];
    // PI 0 means "no level", so it never matches an unassigned status field
    assign hi_en    = (pi_q != 3'd0) && (pi_q == stat_pih);
    assign lo_en    = (pi_q != 3'd0) && (pi_q == stat_pil);

    always_comb begin
        for (int d = 1; d <= 5; d++) begin
            masked[d] = devINTR[d] & {hi_en, hi_en, lo_en, lo_en};
        end
    end

    uba_intr_prio u_prio (
        .req_i   (masked),
        .dev_o   (prio_dev),
        .lvl_o   (prio_lvl),
        .valid_o (prio_valid)
    );

    always_comb begin
        sel_vv   = 1'b0;
        sel_vect = '0;
        for (int d = 1; d <= 5; d++) begin
            if (win_dev_q == 3'(d)) begin
                sel_vv   = devVECTV[d];
                sel_vect = devVECT[d];
            end
        end
    end

`ifdef UBA_INTR_TIMEOUT_EN
    logic [CntW-1:0] cnt_q, cnt_d;

    assign timeout_hit = (cnt_q == CntW'(TIMEOUT));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (state_q == StArb) begin
            cnt_d = '0;
        end else if (state_q == StGrant) begin
            cnt_d = cnt_q + 1'b1;
        end
    end
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT;
    assign timeout_hit    = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            pi_q      <= '0;
            win_dev_q <= '0;
            win_lvl_q <= '0;
            data_q    <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pi_q      <= pi_d;
            win_dev_q <= win_dev_d;
            win_lvl_q <= win_lvl_d;
            data_q    <= data_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pi_d      = pi_q;
        win_dev_d = win_dev_q;
        win_lvl_d = win_lvl_q;
        data_d    = data_q;
        err_d     = err_q;
        unique case (state_q)
            StIdle: begin
                if (vectREAD) begin
                    pi_d    = vectPI;
                    state_d = StArb;
                end
            end
            StArb: begin
                if (prio_valid) begin
                    win_dev_d = prio_dev;
                    win_lvl_d = prio_lvl;
                    state_d   = StGrant;
                end else begin
                    err_d   = 1'b1;
                    data_d  = '0;
                    state_d = StDone;
                end
            end
            StGrant: begin
                // A vector arriving on the timeout cycle still wins
                if (sel_vv) begin
                    err_d   = 1'b0;
                    data_d  = {{PadW{1'b0}}, sel_vect};
                    state_d = StDone;
                end else if (timeout_hit) begin
                    err_d   = 1'b1;
                    data_d  = '0;
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        for (int d = 1; d <= 5; d++) begin
            devACKO[d] = '0;
            if (state_q == StGrant && win_dev_q == 3'(d)) begin
                devACKO[d] = br_onehot(win_lvl_q);
            end
        end
    end

    assign vectDONE = (state_q == StDone);
    assign vectERR  = vectDONE & err_q;
    assign vectDATA = data_q;

endmodule

// File: tb/tb_uba_intr_ack.sv
// Randomized scoreboard bench for uba_intr_ack with a rule-level reference model.
module tb_uba_intr_ack;

    logic        clk = 1'b0;
    logic        rst;
    logic        vectREAD;
    logic [2:0]  vectPI;
    logic [0:35] sr;
    logic [7:4]  intr [1:5];
    logic [15:0] dvect [1:5];
    logic        dvv [1:5];
    logic [7:4]  ack [1:5];
    logic [0:35] vdata;
    logic        vdone;
    logic        verr;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct packed {
        logic        err;
        logic [35:0] data;
    } resp_t;

    resp_t sb [$];
    resp_t mon_e;

    always #5 clk = ~clk;

    uba_intr_ack #(.TIMEOUT(63)) dut (
        .clk      (clk),
        .rst      (rst),
        .vectREAD (vectREAD),
        .vectPI   (vectPI),
        .regUBASR (sr),
        .devINTR  (intr),
        .devVECT  (dvect),
        .devVECTV (dvv),
        .devACKO  (ack),
        .vectDATA (vdata),
        .vectDONE (vdone),
        .vectERR  (verr)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    function automatic logic [19:0] ack_flat();
        return {ack[1], ack[2], ack[3], ack[4], ack[5]};
    endfunction

    // Highest eligible BR first, lowest device number within a BR.
    function automatic bit model(input logic [2:0] pi, output int wd, output int wl);
        logic [2:0] pih;
        logic [2:0] pil;
        pih = sr[30:32];
        pil = sr[33:35];
        wd  = 0;
        wl  = 0;
        if (pi == 3'd0) return 1'b0;
        for (int l = 7; l >= 4; l--) begin
            if ((l >= 6) ? (pi == pih) : (pi == pil)) begin
                for (int d = 1; d <= 5; d++) begin
                    if (intr[d][l]) begin
                        wd = d;
                        wl = l;
                        return 1'b1;
                    end
                end
            end
        end
        return 1'b0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_sr(input logic [2:0] pih, input logic [2:0] pil);
        sr        = {4'($urandom), 32'($urandom)};
        sr[30:32] = pih;
        sr[33:35] = pil;
    endtask

    task automatic clear_intr();
        for (int d = 1; d <= 5; d++) intr[d] = '0;
    endtask

    always @(negedge clk) begin
        if (!rst && vdone) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                mon_e = sb.pop_front();
                check("vect_data", 64'(vdata), 64'(mon_e.data));
                check("vect_err", 64'(verr), 64'(mon_e.err));
            end
        end
    end

    task automatic run_txn(input logic [2:0] pi, input logic [15:0] vec, input int delay,
                           input bit respond, input bit noise);
        int          wd;
        int          wl;
        int          od;
        int          k;
        bit          ok;
        logic [19:0] exp_ack;
        resp_t       r;
        ok      = model(pi, wd, wl);
        exp_ack = '0;
        if (ok) exp_ack[(5 - wd) * 4 + (wl - 4)] = 1'b1;
        if (!ok || !respond) begin
            r.err  = 1'b1;
            r.data = '0;
        end else begin
            r.err  = 1'b0;
            r.data = {20'd0, vec};
        end
        sb.push_back(r);

        vectREAD = 1'b1;
        vectPI   = pi;
        tick();
        vectREAD = 1'b0;
        vectPI   = 3'($urandom);
        tick();
        @(negedge clk);
        if (!ok) begin
            check("nreq_done", 64'(vdone), 1);
            check("nreq_ack", 64'(ack_flat()), 0);
        end else begin
            check("grant", 64'(ack_flat()), 64'(exp_ack));
            if (noise) clear_intr();
            if (!respond) begin
                k = 0;
                do begin
                    tick();
                    @(negedge clk);
                    k++;
                end while (!vdone && k < 200);
                check("timeout_lat", 64'(k), 64);
                check("timeout_ack", 64'(ack_flat()), 0);
            end else begin
                od = (wd % 5) + 1;
                for (int i = 0; i < delay; i++) begin
                    if (noise) begin
                        dvv[od]  = 1'b1;
                        vectREAD = 1'b1;
                        vectPI   = 3'($urandom);
                    end
                    tick();
                    dvv[od]  = 1'b0;
                    vectREAD = 1'b0;
                    @(negedge clk);
                    check("grant_hold", {43'd0, vdone, ack_flat()}, {44'd0, exp_ack});
                end
                dvect[wd] = vec;
                dvv[wd]   = 1'b1;
                tick();
                dvv[wd]   = 1'b0;
                dvect[wd] = 16'($urandom);
                @(negedge clk);
                check("done_lat", 64'(vdone), 1);
                check("ack_clear", 64'(ack_flat()), 0);
            end
        end
        tick();
        @(negedge clk);
        check("done_pulse", 64'(vdone), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        rst      = 1'b1;
        vectREAD = 1'b0;
        vectPI   = '0;
        sr       = '0;
        for (int d = 1; d <= 5; d++) begin
            intr[d]  = '0;
            dvect[d] = 16'($urandom);
            dvv[d]   = 1'b0;
        end
        repeat (3) @(negedge clk);
        check("rst_done", 64'(vdone), 0);
        check("rst_err", 64'(verr), 0);
        check("rst_data", 64'(vdata), 0);
        check("rst_ack", 64'(ack_flat()), 0);
        rst = 1'b0;
        tick();

        // Device 4 BR7 beats device 2 BR6
        set_sr(3'd3, 3'd0);
        clear_intr();
        intr[2] = 4'b0100;
        intr[4] = 4'b1000;
        run_txn(3'd3, 16'o000070, 0, 1'b1, 1'b0);

        // Same BR5: device 1 beats device 3
        set_sr(3'd0, 3'd5);
        clear_intr();
        intr[1] = 4'b0010;
        intr[3] = 4'b0010;
        run_txn(3'd5, 16'($urandom), 2, 1'b1, 1'b0);

        // PI mismatch, then PI 0: no requester
        set_sr(3'd2, 3'd0);
        for (int d = 1; d <= 5; d++) intr[d] = 4'b1111;
        run_txn(3'd6, 16'($urandom), 0, 1'b1, 1'b0);
        set_sr(3'd0, 3'd0);
        run_txn(3'd0, 16'($urandom), 0, 1'b1, 1'b0);

        // Stray vectREAD and non-granted devVECTV during GRANT, requests dropped
        set_sr(3'd4, 3'd4);
        clear_intr();
        intr[3] = 4'b0001;
        intr[5] = 4'b0100;
        run_txn(3'd4, 16'($urandom), 4, 1'b1, 1'b1);

        // Long grant wait; with the timeout compiled in, answer on the timeout cycle
        set_sr(3'd1, 3'd7);
        clear_intr();
        intr[2] = 4'b0010;
`ifdef UBA_INTR_TIMEOUT_EN
        run_txn(3'd7, 16'($urandom), 63, 1'b1, 1'b0);
        run_txn(3'd7, 16'($urandom), 0, 1'b0, 1'b0);
`else
        run_txn(3'd7, 16'($urandom), 100, 1'b1, 1'b0);
`endif

        // Asynchronous reset in the middle of GRANT
        set_sr(3'd3, 3'd0);
        clear_intr();
        intr[5] = 4'b1000;
        vectREAD = 1'b1;
        vectPI   = 3'd3;
        tick();
        vectREAD = 1'b0;
        tick();
        @(negedge clk);
        check("mid_grant", 64'(ack_flat()), 64'(20'h00008));
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_ack", 64'(ack_flat()), 0);
        check("mid_rst_data", 64'(vdata), 0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        run_txn(3'd3, 16'($urandom), 1, 1'b1, 1'b0);

        for (int t = 0; t < 40; t++) begin
            logic [2:0] pih;
            logic [2:0] pil;
            logic [2:0] pi;
            pih = 3'($urandom);
            pil = 3'($urandom);
            set_sr(pih, pil);
            case ($urandom % 3)
                0:       pi = pih;
                1:       pi = pil;
                default: pi = 3'($urandom);
            endcase
            for (int d = 1; d <= 5; d++) intr[d] = 4'($urandom & $urandom);
            run_txn(pi, 16'($urandom), int'($urandom_range(0, 4)), 1'b1, 1'($urandom));
        end

        repeat (3) tick();
        check("sb_drain", 64'(sb.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
